wlmont_stream: RTL and testbench

- Pipelined word-level Montgomery reducer for NTT-friendly moduli (q ≡ 1 mod 2^W), the successor of the fixed single-modulus reducer.
- Adds valid/ready streaming with backpressure and a run-time-writable table of NQ moduli for RNS multi-prime datapaths.
- Adds a per-item modulus select, a per-item lazy mode (skip final subtraction), and a sideband tag that travels with each item.
- Sits after the modular multiplier in butterfly units; computes B = A·2^(-L·W) mod q.

---
 rtl/wlmont_pkg.sv | 23 ++
 rtl/wlmont_step.sv | 72 +++++++
 rtl/wlmont_stream.sv | 139 +++++++++++++
 tb/tb_wlmont_stream.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wlmont_pkg.sv
// Shared width helpers and types for the streaming word-level Montgomery reducer.
// Stage widths shrink by W-1 bits per step but never below LOGQ+1.
package wlmont_pkg;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of the T register written by stage i (i = 0..L-1).
    function automatic int stage_w(input int i, input int logq, input int w);
        return max_int(logq + 1, 2 * logq - (i + 1) * (w - 1));
    endfunction

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [0:0] {
        FIX_FULL = 1'b0,
        FIX_LAZY = 1'b1
    } fix_mode_e;

endpackage

// File: rtl/wlmont_step.sv
// One Montgomery word step for q = 1 mod 2^W: T' = (T >> W) + qH*m + (lo != 0),
// registered together with the item's sideband under a shared pipeline enable.
module wlmont_step
    import wlmont_pkg::*;
#(
    parameter int LOGQ = 60,
    parameter int W    = 15,
    parameter int TAGW = 8,
    parameter int TIN  = 120,
    parameter int TOUT = 106
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    input  logic            i_valid,
    input  logic            i_lazy,
    input  logic [TAGW-1:0] i_tag,
    input  logic [LOGQ-1:0] i_q,
    input  logic [TIN-1:0]  i_t,
    output logic            o_valid,
    output logic            o_lazy,
    output logic [TAGW-1:0] o_tag,
    output logic [LOGQ-1:0] o_q,
    output logic [TOUT-1:0] o_t
);

    logic [W-1:0]      w_lo;
    logic [W-1:0]      w_m;
    logic              w_c;
    logic [LOGQ-W-1:0] w_qh;
    logic [LOGQ-1:0]   w_prod;
    logic [TOUT-1:0]   w_next;

    logic            r_valid;
    logic            r_lazy;
    logic [TAGW-1:0] r_tag;
    logic [LOGQ-1:0] r_q;
    logic [TOUT-1:0] r_t;

    assign w_lo   = i_t[W-1:0];
    assign w_m    = -w_lo;
    assign w_c    = |w_lo;
    assign w_qh   = i_q[LOGQ-1:W];
    assign w_prod = {{W{1'b0}}, w_qh} * {{(LOGQ-W){1'b0}}, w_m};

    // The exact quotient (T + q*m) / 2^W, folded so no wide add of T is needed;
    // the result always fits TOUT, so the casts only drop zero bits.
    assign w_next = TOUT'(i_t >> W) + TOUT'(w_prod) + TOUT'(w_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_lazy  <= 1'b0;
            r_tag   <= '0;
            r_q     <= '0;
            r_t     <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_lazy  <= i_lazy;
            r_tag   <= i_tag;
            r_q     <= i_q;
            r_t     <= w_next;
        end
    end

    assign o_valid = r_valid;
    assign o_lazy  = r_lazy;
    assign o_tag   = r_tag;
    assign o_q     = r_q;
    assign o_t     = r_t;

endmodule

// File: rtl/wlmont_stream.sv
// Streaming multi-modulus word-level Montgomery reducer: B = A * 2^(-L*W) mod q[sel],
// L word steps plus one correction stage, valid/ready with a single global stall enable.
module wlmont_stream
    import wlmont_pkg::*;
#(
    parameter int LOGQ = 60,
    parameter int W    = 15,
    parameter int L    = 4,
    parameter int NQ   = 4,
    parameter int TAGW = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*LOGQ-1:0]           in_a,
    input  logic [clog2_min1(NQ)-1:0]   in_qsel,
    input  logic                        in_lazy,
    input  logic [TAGW-1:0]             in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LOGQ:0]               out_b,
    output logic [TAGW-1:0]             out_tag,
    input  logic                        q_wr_en,
    input  logic [clog2_min1(NQ)-1:0]   q_wr_idx,
    input  logic [LOGQ-1:0]             q_wr_data
);

    typedef struct packed {
        logic            valid;
        logic            lazy;
        logic [TAGW-1:0] tag;
        logic [LOGQ-1:0] q;
    } meta_t;

    logic [LOGQ-1:0]   r_qtab [NQ];
    logic              r_out_valid;
    logic [LOGQ:0]     r_out_b;
    logic [TAGW-1:0]   r_out_tag;

    logic              w_en;
    logic [LOGQ-1:0]   w_qsel_q;

    // Per-boundary pipeline signals; index 0 is the input, index L the last step.
    logic              w_v   [L+1];
    logic              w_lz  [L+1];
    logic [TAGW-1:0]   w_tag [L+1];
    logic [LOGQ-1:0]   w_q   [L+1];
    logic [2*LOGQ-1:0] w_t   [L+1];

    meta_t             w_last;
    logic [LOGQ:0]     w_tl;
    logic [LOGQ+1:0]   w_diff;
    logic              w_borrow;
    fix_mode_e         w_mode;

    assign w_en     = out_ready || !r_out_valid;
    assign in_ready = w_en;

    // Writes land at the edge, so an item accepted on the same edge reads the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NQ; i++) begin
                r_qtab[i] <= '0;
            end
        end else if (q_wr_en && (int'(q_wr_idx) < NQ)) begin
            r_qtab[q_wr_idx] <= q_wr_data;
        end
    end

    assign w_qsel_q = (int'(in_qsel) < NQ) ? r_qtab[in_qsel] : '0;

    assign w_v[0]   = in_valid;
    assign w_lz[0]  = in_lazy;
    assign w_tag[0] = in_tag;
    assign w_q[0]   = w_qsel_q;
    assign w_t[0]   = in_a;

    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_stg
            localparam int TIN  = (gi == 0) ? 2 * LOGQ : stage_w(gi - 1, LOGQ, W);
            localparam int TOUT = stage_w(gi, LOGQ, W);

            logic [TOUT-1:0] w_tout;

            wlmont_step #(
                .LOGQ (LOGQ),
                .W    (W),
                .TAGW (TAGW),
                .TIN  (TIN),
                .TOUT (TOUT)
            ) u_step (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_en    (w_en),
                .i_valid (w_v[gi]),
                .i_lazy  (w_lz[gi]),
                .i_tag   (w_tag[gi]),
                .i_q     (w_q[gi]),
                .i_t     (TIN'(w_t[gi])),
                .o_valid (w_v[gi+1]),
                .o_lazy  (w_lz[gi+1]),
                .o_tag   (w_tag[gi+1]),
                .o_q     (w_q[gi+1]),
                .o_t     (w_tout)
            );

            assign w_t[gi+1] = (2*LOGQ)'(w_tout);
        end
    endgenerate

    assign w_last = '{valid: w_v[L], lazy: w_lz[L], tag: w_tag[L], q: w_q[L]};

    // T_L < 2q, so its low LOGQ+1 bits are exact; one extra bit carries the borrow.
    assign w_tl     = (LOGQ+1)'(w_t[L]);
    assign w_diff   = {1'b0, w_tl} - {2'b00, w_last.q};
    assign w_borrow = w_diff[LOGQ+1];
    assign w_mode   = fix_mode_e'(w_last.lazy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_b     <= '0;
            r_out_tag   <= '0;
        end else if (w_en) begin
            r_out_valid <= w_last.valid;
            if (w_last.valid) begin
                r_out_tag <= w_last.tag;
                r_out_b   <= ((w_mode == FIX_LAZY) || w_borrow) ? w_tl : w_diff[LOGQ:0];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_b     = r_out_b;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_wlmont_stream.sv
// Scoreboard bench for wlmont_stream: expectations come from a one-shot REDC model
// (A + q*M) / 2^16 with M = -A*q^-1 mod 2^16, pushed on accept and popped on emit.
module tb_wlmont_stream;

    localparam int LOGQ = 16;
    localparam int W    = 8;
    localparam int L    = 2;
    localparam int NQ   = 2;
    localparam int TAGW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2*LOGQ-1:0] in_a;
    logic [0:0]        in_qsel;
    logic              in_lazy;
    logic [TAGW-1:0]   in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [LOGQ:0]     out_b;
    logic [TAGW-1:0]   out_tag;
    logic              q_wr_en;
    logic [0:0]        q_wr_idx;
    logic [LOGQ-1:0]   q_wr_data;

    always #5 clk = ~clk;

    wlmont_stream #(
        .LOGQ (LOGQ), .W (W), .L (L), .NQ (NQ), .TAGW (TAGW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_qsel   (in_qsel),
        .in_lazy   (in_lazy),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_tag   (out_tag),
        .q_wr_en   (q_wr_en),
        .q_wr_idx  (q_wr_idx),
        .q_wr_data (q_wr_data)
    );

    typedef struct {
        logic [LOGQ:0]   b;
        logic [TAGW-1:0] tag;
        int              acc;
        bit              lat;
    } exp_t;

    exp_t              exp_q[$];
    int                pop_cyc[$];
    longint unsigned   mq [NQ];
    int                total = 0;
    int                bad   = 0;
    int                cyc   = 0;
    bit                cur_lat = 1'b0;
    bit                rnd_bp  = 1'b0;
    logic [LOGQ:0]     snap_b;
    logic [TAGW-1:0]   snap_tag;

    // B = A * 2^-16 mod q, lazy keeps the REDC representative in [0, 2q).
    function automatic logic [LOGQ:0] model(input longint unsigned a, input longint unsigned q,
                                            input bit lazy);
        longint unsigned mask = (64'd1 << (L * W)) - 1;
        longint unsigned qi   = 1;
        longint unsigned m;
        longint unsigned tl;
        repeat (5) qi = (qi * (2 - q * qi)) & mask;
        m  = ((0 - a) * qi) & mask;
        tl = (a + q * m) >> (L * W);
        if (!lazy && tl >= q) tl = tl - q;
        return tl[LOGQ:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Acceptance side: expected value uses the table as it stood before this edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i < NQ; i++) mq[i] = 0;
        end else begin
            if (in_valid && in_ready) begin
                e.b   = model(in_a, mq[in_qsel], in_lazy);
                e.tag = in_tag;
                e.acc = cyc;
                e.lat = cur_lat;
                exp_q.push_back(e);
            end
            if (q_wr_en) mq[q_wr_idx] = q_wr_data;
        end
    end

    // Monitor: one line per emitted result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out: got b=%0h tag=%0h want no output", out_b, out_tag);
            end else begin
                e = exp_q.pop_front();
                $display("txn tag=%02h b=%05h exp=%05h lat=%0d", out_tag, out_b, e.b, cyc - e.acc);
                chk("out_b", out_b, e.b);
                chk("out_tag", out_tag, e.tag);
                if (e.lat) chk("latency", cyc - e.acc, L + 1);
                pop_cyc.push_back(cyc);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [31:0] a, input int qs, input logic lz,
                        input logic [7:0] tg, input bit lat);
        int n = 0;
        in_a     = a;
        in_qsel  = qs[0:0];
        in_lazy  = lz;
        in_tag   = tg;
        in_valid = 1'b1;
        cur_lat  = lat;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("accept_timeout", 64'(n), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cur_lat  = 1'b0;
    endtask

    task automatic wr_q(input int idx, input logic [15:0] d);
        q_wr_en   = 1'b1;
        q_wr_idx  = idx[0:0];
        q_wr_data = d;
        @(posedge clk);
        #1;
        q_wr_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_q();
        logic [31:0] r = $urandom;
        return {1'b1, r[6:0], 8'h01};
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_qsel   = '0;
        in_lazy   = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        q_wr_en   = 1'b0;
        q_wr_idx  = '0;
        q_wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 0);
        chk("reset_out_b", 64'(out_b), 0);
        chk("reset_out_tag", 64'(out_tag), 0);
        chk("reset_in_ready", 64'(in_ready), 1);
        rst_n = 1'b1;

        wr_q(0, 16'hFF01);
        wr_q(1, 16'hFE01);

        send(32'h0001_0000, 0, 1'b0, 8'h5A, 1'b1);
        drain();

        send(32'h0000_FF01, 0, 1'b0, 8'h11, 1'b0);
        send(32'h0000_FF01, 0, 1'b1, 8'h12, 1'b0);
        send(32'hFF00_0000, 0, 1'b0, 8'h13, 1'b0);
        drain();

        pop_cyc.delete();
        for (int i = 0; i < 4; i++) send(32'h0001_0000, i % 2, 1'b0, 8'(8'h20 + i), 1'b0);
        drain();
        chk("interleave_count", 64'(pop_cyc.size()), 4);
        if (pop_cyc.size() == 4) chk("interleave_rate", 64'(pop_cyc[3] - pop_cyc[0]), 3);

        // Backpressure with three items in flight and a table write in the middle.
        for (int i = 0; i < 3; i++) send($urandom % 32'h4001_0001, 0, 1'b0, 8'(8'h30 + i), 1'b0);
        out_ready = 1'b0;
        q_wr_en   = 1'b1;
        q_wr_idx  = 1'b0;
        q_wr_data = 16'hFD01;
        @(negedge clk);
        snap_b   = out_b;
        snap_tag = out_tag;
        @(posedge clk);
        #1;
        q_wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 0);
            chk("stall_out_valid", 64'(out_valid), 1);
            chk("stall_out_b", 64'(out_b), 64'(snap_b));
            chk("stall_out_tag", 64'(out_tag), 64'(snap_tag));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        send($urandom % 32'h4001_0001, 0, 1'b0, 8'h40, 1'b0);
        send($urandom % 32'h4001_0001, 0, 1'b1, 8'h41, 1'b0);
        drain();

        // Reset with items in flight.
        for (int i = 0; i < 3; i++) send(32'h0001_0000, 0, 1'b0, 8'(8'h50 + i), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 0);
        chk("midreset_out_b", 64'(out_b), 0);
        chk("midreset_out_tag", 64'(out_tag), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_idle", 64'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(32'h0, 0, 1'b0, 8'h60, 1'b0);
        drain();

        // Randomized streaming with backpressure, gaps and concurrent table writes.
        wr_q(0, rand_q());
        wr_q(1, rand_q());
        rnd_bp = 1'b1;
        for (int i = 0; i < 80; i++) begin
            int gap = $urandom_range(0, 3);
            if (gap == 3) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 7) == 0) begin
                q_wr_en   = 1'b1;
                q_wr_idx  = 1'($urandom_range(0, 1));
                q_wr_data = rand_q();
            end
            send($urandom % 32'h4001_0001, int'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
            q_wr_en = 1'b0;
        end
        rnd_bp = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
